// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequencer and its counter core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package counter_seq_pkg;

    localparam int CNT_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/counter_sequencer_core.sv
// Count register with load, increment and wrap/compare; decrement exists only with CNT_DOWN_EN.
// Latency: q_o updates on the edge after a command; at_max_o/at_zero_o are combinational from q_o and mod_n_i.
// Backpressure: none; load_i overrides inc_i/dec_i in the same cycle.
module counter_core
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             inc_i,
`ifdef CNT_DOWN_EN
    input  logic             dec_i,
`endif
    input  logic [WIDTH-1:0] mod_n_i,
    output logic [WIDTH-1:0] q_o,
`ifdef CNT_DOWN_EN
    output logic             at_zero_o,
`endif
    output logic             at_max_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // mod_n is compared live, so a changed terminal value acts on this very cycle.
    // Using >= lets a loaded value above mod_n still wrap to 0 on the next step.
    assign at_max_o = (q_q >= mod_n_i);
`ifdef CNT_DOWN_EN
    assign at_zero_o = (q_q == '0);
`endif
    assign q_o = q_q;

    // Next count: load wins, otherwise step up (or down) with wrap.
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end else if (inc_i) begin
            q_d = at_max_o ? '0 : q_q + 1'b1;
        end
`ifdef CNT_DOWN_EN
        else if (dec_i) begin
            q_d = at_zero_o ? mod_n_i : q_q - 1'b1;
        end
`endif
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Start/stop/load sequencer around a modulo counter; free-running or one-shot. Optional CNT_DOWN_EN adds a dir port.
// Latency: start/stop/load act on the next edge; first count step is one edge after entering RUN; tc is combinational.
// Backpressure: none; load beats start/stop, stop beats start.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int   WIDTH           = CNT_WIDTH_DEFAULT,
    parameter logic ONESHOT_DEFAULT = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_n,
    input  logic             oneshot,
`ifdef CNT_DOWN_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    seq_state_t       state_q, state_d;
    logic             oneshot_q, oneshot_d;
    logic             advance;
    logic             restart;
    logic             at_max;
    logic             term;
    logic             go;
    logic [WIDTH-1:0] restart_val;
    logic [WIDTH-1:0] core_val;
    logic             core_load;

`ifdef CNT_DOWN_EN
    logic             at_zero;

    assign term        = dir ? at_zero : at_max;
    assign restart_val = dir ? mod_n : '0;
`else
    assign term        = at_max;
    assign restart_val = '0;
`endif

    // stop beats start in every state.
    assign go   = start & ~stop;
    assign tc   = (state_q == ST_RUN) & term;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

    // A restart out of DONE reuses the core's load path with the restart value.
    assign core_load = load | restart;
    assign core_val  = load ? load_val : restart_val;

    counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .clr        (clr),
        .load_i     (core_load),
        .load_val_i (core_val),
`ifdef CNT_DOWN_EN
        .inc_i      (advance & ~dir),
        .dec_i      (advance & dir),
        .at_zero_o  (at_zero),
`else
        .inc_i      (advance),
`endif
        .mod_n_i    (mod_n),
        .q_o        (q),
        .at_max_o   (at_max)
    );

    // Next state, oneshot latch and counter commands.
    always_comb begin
        state_d   = state_q;
        oneshot_d = oneshot_q;
        advance   = 1'b0;
        restart   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d   = ST_RUN;
                    oneshot_d = oneshot;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_PAUSE;
                end else if (oneshot_q && term) begin
                    // One-shot ends on the terminal cycle without wrapping.
                    state_d = ST_DONE;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (go) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (go) begin
                    state_d = ST_RUN;
                    restart = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // load overrides everything; the only state effect is leaving DONE for IDLE.
        if (load) begin
            state_d   = (state_q == ST_DONE) ? ST_IDLE : state_q;
            oneshot_d = oneshot_q;
            advance   = 1'b0;
            restart   = 1'b0;
        end
    end

    // State and latched run mode, cleared asynchronously.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            oneshot_q <= ONESHOT_DEFAULT;
        end else begin
            state_q   <= state_d;
            oneshot_q <= oneshot_d;
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: directed scenarios then randomized traffic.
// Latency: one expected entry per clock edge, plus one per asynchronous clear.
// Backpressure: n/a.
module tb_counter_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] mod_n = '0;
    logic         oneshot = 1'b0;
`ifdef CNT_DOWN_EN
    logic         dir = 1'b0;
    logic         dir_nx = 1'b0;
`endif
    logic [W-1:0] q;
    logic         busy;
    logic         tc;
    logic         done;

    int tests = 0;
    int fails = 0;

    counter_sequencer #(
        .WIDTH           (W),
        .ONESHOT_DEFAULT (1'b0)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .stop     (stop),
        .load     (load),
        .load_val (load_val),
        .mod_n    (mod_n),
        .oneshot  (oneshot),
`ifdef CNT_DOWN_EN
        .dir      (dir),
`endif
        .q        (q),
        .busy     (busy),
        .tc       (tc),
        .done     (done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mphase_t;
    mphase_t m_ph = M_IDLE;
    int      m_q  = 0;
    bit      m_os = 1'b0;

    typedef struct {
        string        nm;
        logic [W-1:0] q;
        logic         busy;
        logic         tc;
        logic         done;
    } exp_t;

    exp_t sb[$];

    function automatic bit cur_dn();
`ifdef CNT_DOWN_EN
        return dir;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit at_terminal(input int n);
        if (cur_dn()) return (m_q == 0);
        return (m_q >= n);
    endfunction

    task automatic model_reset();
        m_ph = M_IDLE;
        m_q  = 0;
        m_os = 1'b0;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit ld,
                              input int lv, input int n, input bit os);
        bit go;
        go = st && !sp;
        if (ld) begin
            m_q = lv;
            if (m_ph == M_DONE) m_ph = M_IDLE;
        end else begin
            case (m_ph)
                M_IDLE: if (go) begin m_ph = M_RUN; m_os = os; end
                M_RUN: begin
                    if (sp) m_ph = M_PAUSE;
                    else if (m_os && at_terminal(n)) m_ph = M_DONE;
                    else if (cur_dn()) m_q = (m_q == 0) ? n : m_q - 1;
                    else m_q = (m_q >= n) ? 0 : m_q + 1;
                end
                M_PAUSE: if (go) m_ph = M_RUN;
                M_DONE: if (go) begin m_ph = M_RUN; m_q = cur_dn() ? n : 0; end
                default: m_ph = M_IDLE;
            endcase
        end
    endtask

    task automatic push_exp(input string nm, input int n);
        exp_t e;
        e.nm   = nm;
        e.q    = W'(m_q);
        e.busy = (m_ph == M_RUN);
        e.done = (m_ph == M_DONE);
        e.tc   = (m_ph == M_RUN) && at_terminal(n);
        sb.push_back(e);
    endtask

    // ---------------- stimulus ----------------
    task automatic drive(input logic st, input logic sp, input logic ld,
                         input logic [W-1:0] lv, input logic [W-1:0] n,
                         input logic os, input string nm);
        @(negedge clk);
        clr      = 1'b0;
`ifdef CNT_DOWN_EN
        dir      = dir_nx;
`endif
        start    = st;
        stop     = sp;
        load     = ld;
        load_val = lv;
        mod_n    = n;
        oneshot  = os;
        model_step(st, sp, ld, int'(lv), int'(n), os);
        push_exp(nm, int'(n));
    endtask

    task automatic idle(input int cycles, input logic [W-1:0] n, input string nm);
        for (int i = 0; i < cycles; i++) drive(1'b0, 1'b0, 1'b0, '0, n, 1'b0, nm);
    endtask

    // Clear pulse placed mid-cycle so no clock edge is involved.
    task automatic clr_pulse(input string nm);
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        load  = 1'b0;
        #1;
        model_reset();
        push_exp(nm, int'(mod_n));
        clr = 1'b1;
        #2;
        clr = 1'b0;
        model_step(1'b0, 1'b0, 1'b0, 0, int'(mod_n), 1'b0);
        push_exp({nm, "_after"}, int'(mod_n));
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge clr);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if ({q, busy, tc, done} !== {e.q, e.busy, e.tc, e.done}) begin
                    fails++;
                    $display("FAIL %s @%0t: got q=%0d busy=%0b tc=%0b done=%0b, expected q=%0d busy=%0b tc=%0b done=%0b",
                             e.nm, $time, q, busy, tc, done, e.q, e.busy, e.tc, e.done);
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [W-1:0] rn;
        // Reset state while clr is still held.
        @(negedge clk);
        model_reset();
        push_exp("reset", 0);

        // Free-running 0..9 with wrap.
        drive(1'b1, 1'b0, 1'b0, '0, 4'd9, 1'b0, "free_start");
        idle(11, 4'd9, "free_run");                            // q=1..9,0,1
        // Load above mod_n: tc this cycle, wrap next.
        drive(1'b0, 1'b0, 1'b1, 4'd12, 4'd6, 1'b0, "load_run");
        idle(6, 4'd6, "load_wrap");                            // q=0..5
        // Asynchronous clear at q=5, then no restart without start.
        clr_pulse("clr_mid_run");
        idle(2, 4'd6, "idle_after_clr");

        // One-shot to 15, DONE, restart from 0.
        drive(1'b1, 1'b0, 1'b0, '0, 4'd15, 1'b1, "os_start");
        idle(15, 4'd15, "os_run");                             // q=1..15
        idle(2, 4'd15, "os_done");
        drive(1'b1, 1'b0, 1'b0, '0, 4'd15, 1'b0, "os_restart");
        idle(3, 4'd15, "os_rerun");                            // q=1..3

        // start+stop together: stop wins.
        drive(1'b1, 1'b1, 1'b0, '0, 4'd15, 1'b0, "start_stop");
        idle(2, 4'd15, "paused");
        drive(1'b1, 1'b0, 1'b0, '0, 4'd15, 1'b0, "resume");
        idle(2, 4'd15, "resumed");                             // q=4,5

        // Load in PAUSE, then run to DONE and load out of DONE.
        drive(1'b0, 1'b1, 1'b0, '0, 4'd15, 1'b0, "stop");
        drive(1'b0, 1'b0, 1'b1, 4'd7, 4'd15, 1'b0, "load_pause");
        drive(1'b1, 1'b0, 1'b0, '0, 4'd8, 1'b0, "resume_os");
        idle(2, 4'd8, "to_done");
        drive(1'b0, 1'b0, 1'b1, 4'd3, 4'd8, 1'b0, "load_done");

        // mod_n = 0: q stuck at 0, tc every RUN cycle.
        drive(1'b1, 1'b0, 1'b0, '0, 4'd0, 1'b0, "mod0_start");
        idle(3, 4'd0, "mod0_run");

`ifdef CNT_DOWN_EN
        // Down count from 0 with mod_n = 4.
        clr_pulse("clr_down");
        dir_nx = 1'b1;
        drive(1'b1, 1'b0, 1'b0, '0, 4'd4, 1'b0, "down_start");
        idle(6, 4'd4, "down_run");                             // 4,3,2,1,0,4
`endif

        // Randomized traffic.
        rn = 4'd9;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(99) == 0) begin
                clr_pulse("rnd_clr");
            end else begin
                if ($urandom_range(19) == 0)
                    rn = ($urandom_range(3) == 0) ? '0 : W'($urandom_range(15));
`ifdef CNT_DOWN_EN
                if ($urandom_range(29) == 0) dir_nx = ~dir_nx;
`endif
                drive($urandom_range(4) == 0, $urandom_range(9) == 0,
                      $urandom_range(14) == 0, W'($urandom), rn,
                      1'($urandom_range(1)), "random");
            end
        end

        // Let the monitor drain, bounded.
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
        #3;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits.
REQ-002 Parameter ONESHOT_DEFAULT, default 0, value of the run mode bit after reset (0 = free-running, 1 = one-shot).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin or resume counting.
REQ-006 stop  input  1  one-cycle request to pause counting.
REQ-007 load  input  1  one-cycle request to load load_val into q.
REQ-008 load_val  input  WIDTH  preset value.
REQ-009 mod_n  input  WIDTH  terminal value; the count sequence is 0..mod_n.
REQ-010 oneshot  input  1  sampled on the start edge in IDLE; 1 = stop at terminal.
REQ-011 q  output  WIDTH  current count, registered.
REQ-012 busy  output  1  high in RUN.
REQ-013 tc  output  1  terminal-count flag, combinational from q and state.
REQ-014 done  output  1  high in DONE.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, PAUSE, DONE.
- IDLE: start -> RUN; latch oneshot.
- RUN: stop -> PAUSE.
- RUN, one-shot, tc -> DONE.
- PAUSE: start -> RUN.
- DONE: start -> RUN with q cleared to 0.
REQ-016 In RUN (up mode), q SHALL advance every cycle: q < mod_n -> q+1; q >= mod_n -> 0.
REQ-017 tc SHALL be high exactly while the state is RUN and q >= mod_n.
REQ-018 In one-shot mode, the cycle where tc is high SHALL move the FSM to DONE and hold q at its value, with no wrap.
REQ-019 q SHALL hold in IDLE, PAUSE and DONE.
REQ-020 The state change from start or stop SHALL take effect at the next edge; the first increment after start SHALL occur at the edge following entry to RUN.
REQ-021 load SHALL have priority over counting in every state: q <= load_val; the state is unchanged, except that load in DONE moves the FSM to IDLE.
REQ-022 If start and stop are both high in the same cycle, stop SHALL win: RUN -> PAUSE; IDLE, PAUSE and DONE stay.
REQ-023 load_val > mod_n SHALL be accepted; the next RUN increment wraps q to 0 and tc is high for that cycle.
REQ-024 mod_n = 0 SHALL keep q at 0 in RUN, with tc high on every RUN cycle.
REQ-025 mod_n changes SHALL take effect on the same cycle's comparison; mod_n is not latched.

Reset
REQ-026 While clr is high: state = IDLE, q = 0, latched oneshot = ONESHOT_DEFAULT, busy = tc = done = 0, independent of clk.
REQ-027 clr asserted mid-RUN SHALL abort immediately; after release, the FSM SHALL require a new start.

Configuration
REQ-028 Macro CNT_DOWN_EN: when defined, add port dir (input, 1, 0 = up, 1 = down).
- Down mode in RUN: q > 0 -> q-1; q == 0 -> mod_n.
- Down mode: tc is high when q == 0; one-shot stops at 0; DONE -> RUN on start reloads mod_n.
REQ-029 Without CNT_DOWN_EN, the dir port SHALL be absent and behaviour SHALL be up-only exactly as REQ-016..REQ-018.

Structure
REQ-030 The shared package counter_seq_pkg SHALL hold the FSM state enum (2-bit: IDLE = 0, RUN = 1, PAUSE = 2, DONE = 3) and the default WIDTH constant.
REQ-031 Sub-module counter_core SHALL implement the q register with clr, load, inc and dec (dec only under CNT_DOWN_EN), plus the wrap/compare; counter_sequencer holds the FSM and drives counter_core.

Verification
REQ-032 Scenario: clr pulse during RUN at q = 5 -> q = 0, state IDLE, busy = 0 within the same cycle, with no clk edge needed.
REQ-033 Scenario: mod_n = 9, oneshot = 0, start -> q = 1,2,...,9,0,1; tc high only while q = 9; busy stays 1.
REQ-034 Scenario: mod_n = 15, oneshot = 1, start -> q counts to 15; the next cycle gives done = 1, busy = 0, q = 15; start again -> q = 0, then 1.
REQ-035 Scenario: in RUN at q = 3, start and stop in the same cycle -> PAUSE, q holds 3; a later start resumes 4,5.
REQ-036 Scenario: mod_n = 6, load with load_val = 12 during RUN -> q = 12, tc = 1, next q = 0; load during PAUSE -> q = load_val, state PAUSE.
REQ-037 Scenario (CNT_DOWN_EN): dir = 1, mod_n = 4, q = 0, start -> 4,3,2,1,0,4; tc high while q = 0.
